seg_multi_driver: RTL

Parametrised multi-digit seven-segment driver. It converts an unsigned binary value into `DIGITS` active-low segment patterns using a sequential shift-add-3 (double-dabble) converter instead of combinational divide/modulo. It supports leading-zero blanking and overflow indication. It sits between a counter/timer core and the board's seven-segment pins, and accepts new values through a valid/ready handshake.

---
 rtl/seg_multi_driver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seg_multi_driver.sv
// seg_multi_driver: multi-digit active-low seven-segment driver.
// Binary input is converted to BCD with a sequential shift-add-3 loop
// (one bit per cycle), then decoded and registered onto the segment pins.
// Optional feature macro: SEG_MULTI_DRIVER_LZB_EN enables leading-zero blanking.
module seg_multi_driver #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [WIDTH-1:0]      i_num,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [8*DIGITS-1:0]   o_seg
);

  localparam int BW = 4*DIGITS;
  // Comparison width wide enough for both the input and 10^DIGITS (< 2^BW).
  localparam int CW = ((WIDTH > BW) ? WIDTH : BW) + 1;
  localparam int NW = $clog2(WIDTH+1);

  function automatic logic [CW-1:0] pow10(input int n);
    logic [CW-1:0] p;
    p = CW'(1);
    for (int i = 0; i < n; i++) p = p * CW'(10);
    return p;
  endfunction

  localparam logic [CW-1:0] LIMIT = pow10(DIGITS);

  // Active-low patterns with dp off.
  function automatic logic [7:0] dec7(input logic [3:0] n);
    case (n)
      4'd0:    dec7 = 8'hC0;
      4'd1:    dec7 = 8'hF9;
      4'd2:    dec7 = 8'hA4;
      4'd3:    dec7 = 8'hB0;
      4'd4:    dec7 = 8'h99;
      4'd5:    dec7 = 8'h92;
      4'd6:    dec7 = 8'h82;
      4'd7:    dec7 = 8'hF8;
      4'd8:    dec7 = 8'h80;
      4'd9:    dec7 = 8'h90;
      default: dec7 = 8'hFF;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [NW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;       // overflow of the value in flight
  logic [8*DIGITS-1:0] seg_q, seg_d;
  logic                ovf_o_q, ovf_o_d;   // overflow of the value on display
  logic                done_q, done_d;
  logic                ready_q, ready_d;

  logic [BW-1:0]       bcd_adj;
  logic [8*DIGITS-1:0] seg_disp;

  // Add-3 correction on every nibble that would exceed 9 after doubling.
  always_comb begin
    bcd_adj = '0;
    for (int k = 0; k < DIGITS; k++)
      bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                     : bcd_q[4*k +: 4];
  end

  // Segment image of the finished conversion: dashes on overflow, else digits.
`ifdef SEG_MULTI_DRIVER_LZB_EN
  always_comb begin
    logic seen;
    seen     = 1'b0;
    seg_disp = '1;
    for (int k = DIGITS-1; k >= 0; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) seen = 1'b1;
      // digit 0 always shows so that zero reads "0"
      seg_disp[8*k +: 8] = (seen || k == 0) ? dec7(bcd_q[4*k +: 4]) : 8'hFF;
      if (ovf_q) seg_disp[8*k +: 8] = 8'hBF;
    end
  end
`else
  always_comb begin
    seg_disp = '1;
    for (int k = 0; k < DIGITS; k++)
      seg_disp[8*k +: 8] = ovf_q ? 8'hBF : dec7(bcd_q[4*k +: 4]);
  end
`endif

  // Next-state and datapath control for accept / shift / load.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    seg_d   = seg_q;
    ovf_o_d = ovf_o_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          bin_d   = i_num;
          bcd_d   = '0;
          ovf_d   = ({{(CW-WIDTH){1'b0}}, i_num} >= LIMIT);
          cnt_d   = NW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // bits leaving the BCD MSB only matter on overflow, which is masked
        bcd_d = BW'({bcd_adj, bin_q[WIDTH-1]});
        bin_d = bin_q << 1;
        cnt_d = cnt_q - NW'(1);
        if (cnt_q == NW'(1)) state_d = LOAD;
      end
      LOAD: begin
        seg_d   = seg_disp;
        ovf_o_d = ovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      seg_q   <= '1;
      ovf_o_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
      ovf_o_q <= ovf_o_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign o_seg      = seg_q;
  assign o_overflow = ovf_o_q;
  assign o_done     = done_q;
  assign o_ready    = ready_q;

endmodule
